dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-ported data_mem, which has ports clk, r, w, addr, wdata and rdata. It shares the memory between requester 0 (CPU load/store path) and requester 1 (loader/debug port) using req/ack handshakes. It serialises accesses, drives the memory strobes for exactly the required cycles, and returns read data with an ack pulse.

Parameters:
AW, 32, address width (passed unchanged to data_mem)
DW, 32, data width
RD_LAT, 1, cycles mem_r is held before mem_rdata is valid and sampled (legal 1..3)
FAIR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active low
p0_req  in  1  port 0 request; held with payload stable until p0_ack
p0_we  in  1  port 0: 1 = write, 0 = read
p0_addr  in  AW  port 0 address
p0_wdata  in  DW  port 0 write data
p0_ack  out  1  port 0 one-cycle completion pulse
p0_rdata  out  DW  port 0 read data, valid with p0_ack and held until the next port 0 read ack
p1_req/p1_we/p1_addr/p1_wdata/p1_ack/p1_rdata  same as port 0, for port 1
mem_r  out  1  data_mem read strobe
mem_w  out  1  data_mem write strobe
mem_addr  out  AW  data_mem address
mem_wdata  out  DW  data_mem write data
mem_rdata  in  DW  data_mem read data
busy  out  1  high whenever state != IDLE
grant_id  out  1  port currently being served; meaningful only while busy

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE; mem_r, mem_w, mem_addr, mem_wdata, p0_ack, p1_ack, p0_rdata, p1_rdata, busy and grant_id all 0; last_grant=1, so port 0 wins the first tie.
- All outputs are registered or decoded from registered state only. No combinational path from any req to any mem_* output.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, arbitrate and latch id, we, addr and wdata into registers, then go to ISSUE.
  - Arbitration with both requests high: FAIR=1 grants the port != last_grant; FAIR=0 grants port 0.
  - last_grant is updated to the granted id.
- ISSUE, write:
  - mem_w=1 for exactly this one cycle, with the latched mem_addr and mem_wdata; memory commits at the closing edge.
  - Next state RESP.
- ISSUE, read:
  - mem_r=1.
  - If RD_LAT=1: sample mem_rdata at the closing edge into the granted port's rdata register, then go to RESP.
  - Otherwise go to WAIT.
- WAIT:
  - mem_r stays high and a counter runs for RD_LAT-1 cycles.
  - mem_rdata is sampled at the closing edge of the last WAIT cycle, then go to RESP.
  - Total mem_r high time is exactly RD_LAT cycles.
- RESP:
  - Granted port's ack=1 for one cycle; mem_r=mem_w=0.
  - Next state is always IDLE. IDLE re-samples req on the following cycle, so a requester that drops or changes req after ack is never double-served.
- Latency, from the cycle req is first seen in IDLE (T):
  - Write ack in T+2.
  - Read ack in T+1+RD_LAT.
  - Minimum issue interval is 3 cycles for writes and 2+RD_LAT cycles for reads.
- mem_addr and mem_wdata hold their last latched values outside ISSUE/WAIT. The strobes are the only qualifiers.
- Non-granted port: its ack stays 0 and its rdata register is unchanged.
- Port drops req before ack: this is a protocol violation. The in-flight transaction still completes and acks.
- Reset mid-operation:
  - Outputs are already registered for the cycle in which rst_n is sampled low, so a write in ISSUE that cycle still commits.
  - At that edge the FSM returns to IDLE. No ack is ever produced for the aborted transaction.
  - last_grant returns to 1.
- Address and data are passed to data_mem unmodified; there is no width conversion.

Test Plan:
1. Hold rst_n=0 for 2 cycles with both reqs high -> all outputs 0 and busy=0 throughout; first grant after release goes to port 0.
2. p0 write addr=2 wdata=9, then p0 read addr=2 (RD_LAT=1) -> mem_w high exactly 1 cycle with mem_addr=2, mem_wdata=9; write ack at T+2; read ack at T+2 with p0_rdata=9.
3. p0 write addr=4 data=5 and p1 write addr=8 data=7 raised in the same cycle and held -> grant_id 0 then 1, one mem_w pulse each. Follow-up reads return p0_rdata=5 and p1_rdata=7.
4. Both ports issue reads continuously for 4 transactions -> FAIR=1 gives grant order 0,1,0,1; FAIR=0 gives 0,0,0,0 with p1_ack never asserted.
5. RD_LAT=3, p1 read addr=8 -> mem_r high for exactly 3 consecutive cycles; p1_ack in T+4 with p1_rdata=7; p0_rdata unchanged.
6. RD_LAT=2, assert rst_n=0 during WAIT of a p1 read -> no p1_ack, busy=0 after the edge. A subsequent p1 write addr=12 data=3 completes normally with ack at T+2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer sharing one single-ported data memory between a CPU port and a loader port.
// Latency: write ack at T+2, read ack at T+1+RD_LAT, where T is the cycle the request is first seen idle.
// Backpressure: a requester holds req and payload until its ack; the other port simply waits for arbitration.
module dmem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1,
    parameter int FAIR   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_r,
    output logic          mem_w,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // WAIT counts RD_LAT-1 cycles; the last one is the cycle whose closing edge samples the memory.
    localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t     state;
    state_t     state_nxt;
    logic       we_q;
    logic       last_grant;
    logic [1:0] wait_cnt;
    logic       pick;
    logic       sample;

    // State register; reset aborts any in-flight transaction without an ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, arbitration choice and strobes, all decoded from registered state only.
    always_comb begin
        state_nxt = state;
        pick      = 1'b0;
        sample    = 1'b0;
        mem_r     = 1'b0;
        mem_w     = 1'b0;
        p0_ack    = 1'b0;
        p1_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_nxt = ISSUE;
                    if (p0_req && p1_req) begin
                        pick = (FAIR != 0) ? ~last_grant : 1'b0;
                    end else begin
                        pick = p1_req;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    mem_w     = 1'b1;
                    state_nxt = RESP;
                end else begin
                    mem_r = 1'b1;
                    if (RD_LAT <= 1) begin
                        sample    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                mem_r = 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                    sample    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                p0_ack    = ~grant_id;
                p1_ack    = grant_id;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Latch the winning request, run the read-latency counter and capture read data for the granted port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wait_cnt   <= 2'd0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            if (state == IDLE && (p0_req || p1_req)) begin
                grant_id   <= pick;
                last_grant <= pick;
                we_q       <= pick ? p1_we    : p0_we;
                mem_addr   <= pick ? p1_addr  : p0_addr;
                mem_wdata  <= pick ? p1_wdata : p0_wdata;
            end
            if (state == ISSUE) begin
                wait_cnt <= 2'd0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 2'd1;
            end
            if (sample) begin
                if (grant_id) begin
                    p1_rdata <= mem_rdata;
                end else begin
                    p0_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: four instances (RD_LAT/FAIR variants) each with a latency-aware memory model.
// Latency: checked per transaction against hand-computed ack cycles.
// Backpressure: requesters hold req until ack, then drop it.
module tb_dmem_arbiter;

    logic        clk;
    logic        mem_clr;
    logic        rst_n    [4];
    logic        p0_req   [4];
    logic        p0_we    [4];
    logic [31:0] p0_addr  [4];
    logic [31:0] p0_wdata [4];
    logic        p0_ack   [4];
    logic [31:0] p0_rdata [4];
    logic        p1_req   [4];
    logic        p1_we    [4];
    logic [31:0] p1_addr  [4];
    logic [31:0] p1_wdata [4];
    logic        p1_ack   [4];
    logic [31:0] p1_rdata [4];
    logic        mem_r    [4];
    logic        mem_w    [4];
    logic [31:0] mem_addr [4];
    logic [31:0] mem_wdata[4];
    logic [31:0] mem_rdata[4];
    logic        busy     [4];
    logic        grant_id [4];

    int n_pass;
    int n_total;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instance 0: RD_LAT=1 FAIR=1; 1: RD_LAT=1 FAIR=0; 2: RD_LAT=3; 3: RD_LAT=2.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : ((g == 3) ? 2 : 1);
        localparam int FR  = (g == 1) ? 0 : 1;
        logic [31:0] mem [16];
        int rcnt;

        // Memory model: data only valid in the RD_LAT-th consecutive cycle of mem_r.
        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            end else if (mem_w[g]) begin
                mem[mem_addr[g][3:0]] <= mem_wdata[g];
            end
            rcnt <= mem_r[g] ? rcnt + 1 : 0;
        end
        assign mem_rdata[g] = (mem_r[g] && rcnt == LAT - 1) ? mem[mem_addr[g][3:0]] : 32'hBAD0_BAD0;

        dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT), .FAIR(FR)) u_dut (
            .clk(clk), .rst_n(rst_n[g]),
            .p0_req(p0_req[g]), .p0_we(p0_we[g]), .p0_addr(p0_addr[g]), .p0_wdata(p0_wdata[g]),
            .p0_ack(p0_ack[g]), .p0_rdata(p0_rdata[g]),
            .p1_req(p1_req[g]), .p1_we(p1_we[g]), .p1_addr(p1_addr[g]), .p1_wdata(p1_wdata[g]),
            .p1_ack(p1_ack[g]), .p1_rdata(p1_rdata[g]),
            .mem_r(mem_r[g]), .mem_w(mem_w[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]), .busy(busy[g]), .grant_id(grant_id[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct {
        int          dut;
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    // One single-port transaction: raise req in an idle cycle, wait for ack, check timing and side effects.
    task automatic do_txn(input int d, input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input int exp_lat,
                          input string tag);
        logic [31:0] other_before;
        int lat, nw, nr;
        bit seen, other_ack;
        @(negedge clk);
        chk({tag, " idle"}, 32'(busy[d]), 32'h0);
        other_before = port ? p0_rdata[d] : p1_rdata[d];
        if (port) begin
            p1_we[d] = we; p1_addr[d] = addr; p1_wdata[d] = wdata; p1_req[d] = 1'b1;
        end else begin
            p0_we[d] = we; p0_addr[d] = addr; p0_wdata[d] = wdata; p0_req[d] = 1'b1;
        end
        lat = 0; nw = 0; nr = 0; seen = 0; other_ack = 0;
        for (int n = 1; n <= 12 && !seen; n++) begin
            @(negedge clk);
            if (mem_w[d]) nw++;
            if (mem_r[d]) nr++;
            if (port ? p0_ack[d] : p1_ack[d]) other_ack = 1;
            if (port ? p1_ack[d] : p0_ack[d]) begin
                seen = 1;
                lat  = n;
                chk({tag, " grant_id"}, 32'(grant_id[d]), 32'(port));
                chk({tag, " mem_addr"}, mem_addr[d], addr);
            end
        end
        if (port) p1_req[d] = 1'b0; else p0_req[d] = 1'b0;
        chk({tag, " ack latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " other ack"}, 32'(other_ack), 32'h0);
        chk({tag, " other rdata"}, port ? p0_rdata[d] : p1_rdata[d], other_before);
        if (we) begin
            chk({tag, " mem_w cycles"}, 32'(nw), 32'd1);
            chk({tag, " mem_r cycles"}, 32'(nr), 32'd0);
            chk({tag, " mem_wdata"}, mem_wdata[d], wdata);
        end else begin
            chk({tag, " mem_r cycles"}, 32'(nr), 32'(exp_lat - 1));
            chk({tag, " mem_w cycles"}, 32'(nw), 32'd0);
            chk({tag, " rdata"}, port ? p1_rdata[d] : p0_rdata[d], exp_rd);
        end
    endtask

    initial begin
        int nw, g0, g1;
        logic [31:0] a0, a1, w0, w1;
        bit k0, k1, any_ack;
        int ord [2][4];
        int cnt [2];

        n_pass  = 0;
        n_total = 0;
        mem_clr = 1'b1;
        for (int d = 0; d < 4; d++) begin
            rst_n[d] = 1'b0;
            p0_req[d] = 1'b1; p0_we[d] = 1'b0; p0_addr[d] = 32'h0; p0_wdata[d] = 32'h0;
            p1_req[d] = 1'b1; p1_we[d] = 1'b0; p1_addr[d] = 32'h0; p1_wdata[d] = 32'h0;
        end

        vecs[0]  = '{0, 1'b0, 1'b1, 32'd2, 32'd9,    32'd0,    2};
        vecs[1]  = '{0, 1'b0, 1'b0, 32'd2, 32'd0,    32'd9,    2};
        vecs[2]  = '{0, 1'b1, 1'b1, 32'd5, 32'h55,   32'd0,    2};
        vecs[3]  = '{0, 1'b1, 1'b0, 32'd5, 32'd0,    32'h55,   2};
        vecs[4]  = '{0, 1'b0, 1'b0, 32'd5, 32'd0,    32'h55,   2};
        vecs[5]  = '{0, 1'b1, 1'b0, 32'd2, 32'd0,    32'd9,    2};
        vecs[6]  = '{1, 1'b1, 1'b1, 32'd3, 32'h33,   32'd0,    2};
        vecs[7]  = '{1, 1'b1, 1'b0, 32'd3, 32'd0,    32'h33,   2};
        vecs[8]  = '{2, 1'b1, 1'b1, 32'd8, 32'd7,    32'd0,    2};
        vecs[9]  = '{2, 1'b1, 1'b0, 32'd8, 32'd0,    32'd7,    4};
        vecs[10] = '{3, 1'b1, 1'b1, 32'd6, 32'h66,   32'd0,    2};
        vecs[11] = '{3, 1'b1, 1'b0, 32'd6, 32'd0,    32'h66,   3};

        // Reset held two cycles with both requests high: everything stays zero.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("rst%0d busy d%0d", c, d), 32'(busy[d]), 32'h0);
                chk($sformatf("rst%0d strobes d%0d", c, d), {30'h0, mem_r[d], mem_w[d]}, 32'h0);
                chk($sformatf("rst%0d acks d%0d", c, d), {30'h0, p0_ack[d], p1_ack[d]}, 32'h0);
            end
            chk($sformatf("rst%0d grant_id", c), 32'(grant_id[0]), 32'h0);
            chk($sformatf("rst%0d mem_addr", c), mem_addr[0], 32'h0);
            chk($sformatf("rst%0d mem_wdata", c), mem_wdata[0], 32'h0);
            chk($sformatf("rst%0d p0_rdata", c), p0_rdata[0], 32'h0);
            chk($sformatf("rst%0d p1_rdata", c), p1_rdata[0], 32'h0);
        end
        mem_clr = 1'b0;
        for (int d = 0; d < 4; d++) rst_n[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("first grant busy d%0d", d), 32'(busy[d]), 32'h1);
            chk($sformatf("first grant id d%0d", d), 32'(grant_id[d]), 32'h0);
            p0_req[d] = 1'b0;
            p1_req[d] = 1'b0;
        end
        @(negedge clk);
        chk("early drop still acks", 32'(p0_ack[0]), 32'h1);
        repeat (6) @(negedge clk);

        // Directed single-port transactions.
        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].dut, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rd, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Simultaneous writes from both ports on the round-robin instance.
        @(negedge clk);
        p0_we[0] = 1'b1; p0_addr[0] = 32'd4; p0_wdata[0] = 32'd5; p0_req[0] = 1'b1;
        p1_we[0] = 1'b1; p1_addr[0] = 32'd8; p1_wdata[0] = 32'd7; p1_req[0] = 1'b1;
        nw = 0; g0 = -1; g1 = -1; a0 = 0; a1 = 0; w0 = 0; w1 = 0; k0 = 0; k1 = 0;
        for (int n = 0; n < 20 && !(k0 && k1); n++) begin
            @(negedge clk);
            if (mem_w[0]) begin
                if (nw == 0) begin g0 = int'(grant_id[0]); a0 = mem_addr[0]; w0 = mem_wdata[0]; end
                else begin g1 = int'(grant_id[0]); a1 = mem_addr[0]; w1 = mem_wdata[0]; end
                nw++;
            end
            if (p0_ack[0]) begin k0 = 1; p0_req[0] = 1'b0; end
            if (p1_ack[0]) begin k1 = 1; p1_req[0] = 1'b0; end
        end
        p0_req[0] = 1'b0; p1_req[0] = 1'b0;
        chk("dual write pulses", 32'(nw), 32'd2);
        chk("dual write grant first", 32'(g0), 32'd0);
        chk("dual write addr first", a0, 32'd4);
        chk("dual write data first", w0, 32'd5);
        chk("dual write grant second", 32'(g1), 32'd1);
        chk("dual write addr second", a1, 32'd8);
        chk("dual write data second", w1, 32'd7);
        chk("dual write both acked", {30'h0, k0, k1}, 32'h3);
        do_txn(0, 1'b0, 1'b0, 32'd4, 32'd0, 32'd5, 2, "dual rd p0");
        do_txn(0, 1'b1, 1'b0, 32'd8, 32'd0, 32'd7, 2, "dual rd p1");

        // Continuous reads from both ports: round-robin vs fixed priority.
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0;
            for (int i = 0; i < 4; i++) ord[d][i] = -1;
            p0_we[d] = 1'b0; p0_addr[d] = 32'd4; p0_req[d] = 1'b1;
            p1_we[d] = 1'b0; p1_addr[d] = 32'd8; p1_req[d] = 1'b1;
        end
        any_ack = 0;
        for (int n = 0; n < 40 && (cnt[0] < 4 || cnt[1] < 4); n++) begin
            @(negedge clk);
            if (p1_ack[1]) any_ack = 1;
            for (int d = 0; d < 2; d++) begin
                if (cnt[d] < 4) begin
                    if (p0_ack[d]) begin ord[d][cnt[d]] = 0; cnt[d]++; end
                    if (p1_ack[d]) begin ord[d][cnt[d]] = 1; cnt[d]++; end
                    if (cnt[d] == 4) begin p0_req[d] = 1'b0; p1_req[d] = 1'b0; end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin p0_req[d] = 1'b0; p1_req[d] = 1'b0; end
        repeat (6) begin
            @(negedge clk);
            if (p1_ack[1]) any_ack = 1;
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr order %0d", i), 32'(ord[0][i]), 32'(i % 2));
            chk($sformatf("fixed order %0d", i), 32'(ord[1][i]), 32'd0);
        end
        chk("fixed p1 never acked", 32'(any_ack), 32'h0);

        // Reset during WAIT of a port-1 read on the RD_LAT=2 instance.
        @(negedge clk);
        p1_we[3] = 1'b0; p1_addr[3] = 32'd6; p1_req[3] = 1'b1;
        @(negedge clk);
        chk("abort issue mem_r", 32'(mem_r[3]), 32'h1);
        @(negedge clk);
        chk("abort wait busy", 32'(busy[3]), 32'h1);
        chk("abort wait mem_r", 32'(mem_r[3]), 32'h1);
        rst_n[3] = 1'b0;
        p1_req[3] = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy[3]), 32'h0);
        chk("abort mem_r", 32'(mem_r[3]), 32'h0);
        chk("abort p1_rdata reset", p1_rdata[3], 32'h0);
        any_ack = p1_ack[3];
        rst_n[3] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (p1_ack[3]) any_ack = 1;
        end
        chk("abort no ack", 32'(any_ack), 32'h0);
        do_txn(3, 1'b1, 1'b1, 32'd12, 32'd3, 32'd0, 2, "post abort wr");
        do_txn(3, 1'b1, 1'b0, 32'd12, 32'd0, 32'd3, 3, "post abort rd");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
